// File: rtl/gb_bus_pkg.sv
// Shared definitions for the Game Boy cartridge bus interface.
//   state_t    : read-path FSM states
//   ROM_A15    : value of the top address bit for the ROM window (0x0000-0x7FFF)
//   SRAM_TOP3  : top three address bits of the external SRAM window (0xA000-0xBFFF)
//   *_DEF      : default parameter values for the bus interface
package gb_bus_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CYC_DEF  = 2;

    localparam logic       ROM_A15   = 1'b0;
    localparam logic [2:0] SRAM_TOP3 = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/gb_sync.sv
// N-stage single-bit synchronizer.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; every stage loads RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module gb_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {N{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[N-2:0], d};
        end
    end

    assign q = sync_reg[N-1];

endmodule

// File: rtl/gb_cart_bus_if.sv
// Cartridge-side Game Boy bus interface.
// Converts the asynchronous GB strobes into single-clock backend transactions:
// a level read request held until rd_ack, and a one-cycle write strobe.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   gb_addr             : raw cartridge address pins
//   gb_rd_n/wr_n/cs_n   : raw active-low GB strobes
//   pad_d_in            : data from the pad input registers
//   pad_d_out, pad_oe   : data and per-bit output enable to the pad (all oe bits equal)
//   rd_req, rd_addr     : backend read request and its address
//   rd_data, rd_ack     : backend read data and one-cycle completion
//   wr_valid, wr_addr,
//   wr_data             : one-cycle write strobe with captured address/data
module gb_cart_bus_if
    import gb_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CYC  = STABLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] gb_addr,
    input  logic              gb_rd_n,
    input  logic              gb_wr_n,
    input  logic              gb_cs_n,
    input  logic [DATA_W-1:0] pad_d_in,
    output logic [DATA_W-1:0] pad_d_out,
    output logic [DATA_W-1:0] pad_oe,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ack,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int                STAB_W   = $clog2(STABLE_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);

    // Strobe synchronizers: bit 0 rd_n, bit 1 wr_n, bit 2 cs_n; reset to inactive.
    logic [2:0] strobe_raw;
    logic [2:0] strobe_s;
    logic       rd_n_s, wr_n_s, cs_n_s;

    assign strobe_raw = {gb_cs_n, gb_wr_n, gb_rd_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        gb_sync #(
            .N       (SYNC_STAGES),
            .RST_VAL (1'b1)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (strobe_raw[gi]),
            .q     (strobe_s[gi])
        );
    end

    assign rd_n_s = strobe_s[0];
    assign wr_n_s = strobe_s[1];
    assign cs_n_s = strobe_s[2];

    // Address stability filter. The registered address is compared with its
    // own previous value so the raw pins never feed the counter logic.
    logic [ADDR_W-1:0] addr_q, addr_prev;
    logic [STAB_W-1:0] stab_cnt;
    logic              addr_ok;
    logic [ADDR_W-1:0] stable_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            addr_prev <= '0;
            stab_cnt  <= '0;
        end else begin
            addr_q    <= gb_addr;
            addr_prev <= addr_q;
            if (addr_q != addr_prev) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // The equality term masks the one cycle where a fresh change is visible
    // in addr_q but the counter has not been cleared yet.
    assign addr_ok     = (stab_cnt == STAB_MAX) && (addr_q == addr_prev);
    assign stable_addr = addr_q;

    // Address decode
    logic rom_hit, ram_hit, sel;

    assign rom_hit = (stable_addr[ADDR_W-1] == ROM_A15);
    assign ram_hit = (stable_addr[ADDR_W-1 -: 3] == SRAM_TOP3) && !cs_n_s;
    assign sel     = rom_hit | ram_hit;

    // Read FSM
    state_t            state_reg, state_next;
    logic              rd_req_reg, rd_req_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic [DATA_W-1:0] pad_d_out_reg, pad_d_out_next;
    logic              oe_reg, oe_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rd_req_reg    <= 1'b0;
            rd_addr_reg   <= '0;
            pad_d_out_reg <= '0;
            oe_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_req_reg    <= rd_req_next;
            rd_addr_reg   <= rd_addr_next;
            pad_d_out_reg <= pad_d_out_next;
            oe_reg        <= oe_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rd_req_next    = rd_req_reg;
        rd_addr_next   = rd_addr_reg;
        pad_d_out_next = pad_d_out_reg;
        oe_next        = oe_reg;

        if (!wr_n_s) begin
            // A write cycle owns the bus, including a simultaneous read strobe.
            state_next  = IDLE;
            rd_req_next = 1'b0;
            oe_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!rd_n_s && addr_ok && sel) begin
                        state_next   = REQ;
                        rd_req_next  = 1'b1;
                        rd_addr_next = stable_addr;
                    end
                end
                REQ: begin
                    if (rd_n_s || (addr_ok && !sel)) begin
                        // Abandoned read: any later rd_ack lands in IDLE and is dropped.
                        state_next  = IDLE;
                        rd_req_next = 1'b0;
                        oe_next     = 1'b0;
                    end else if (rd_ack) begin
                        state_next     = DRIVE;
                        rd_req_next    = 1'b0;
                        pad_d_out_next = rd_data;
                        oe_next        = 1'b1;
                    end
                end
                DRIVE: begin
                    if (rd_n_s || (addr_ok && !sel)) begin
                        state_next = IDLE;
                        oe_next    = 1'b0;
                    end else if (addr_ok && (stable_addr != rd_addr_reg)) begin
                        // New address under a held read strobe: keep driving the
                        // old byte until the backend answers the new request.
                        state_next   = REQ;
                        rd_req_next  = 1'b1;
                        rd_addr_next = stable_addr;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    rd_req_next = 1'b0;
                    oe_next     = 1'b0;
                end
            endcase
        end
    end

    // Write path: track address/data while the strobe is low, emit on its release.
    logic              wr_n_d;
    logic              wr_rise;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_reg;
    logic [DATA_W-1:0] wr_data_q, wr_data_reg;
    logic              wr_valid_reg;

    assign wr_rise = wr_n_s & ~wr_n_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_d       <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_n_d       <= wr_n_s;
            wr_valid_reg <= wr_rise;
            if (!wr_n_s) begin
                wr_addr_q <= addr_q;
                wr_data_q <= pad_d_in;
            end
            if (wr_rise) begin
                wr_addr_reg <= wr_addr_q;
                wr_data_reg <= wr_data_q;
            end
        end
    end

    assign pad_d_out = pad_d_out_reg;
    assign pad_oe    = {DATA_W{oe_reg}};
    assign rd_req    = rd_req_reg;
    assign rd_addr   = rd_addr_reg;
    assign wr_valid  = wr_valid_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;

endmodule
